// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, image framing
// constants and the word-address helper.
package loader_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_HDR_HI = 3'd1;
  localparam logic [2:0] ST_HDR_LO = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;
  localparam logic [2:0] ST_CHK    = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;
  localparam logic [2:0] ST_ERR    = 3'd7;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int CSUM_W         = 8;

  // Byte address of word idx; wraps silently in 32 bits.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [15:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Big-endian byte-to-word shift register: the first byte loaded ends up in
// [31:24]; word_full flags the load that completes a word.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_full
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear) begin
      word_d = 32'd0;
      cnt_d  = 2'd0;
    end else if (load) begin
      word_d = {word_q[23:0], byte_in};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  assign word_next = word_d;
  assign word_full = load && !clear && (cnt_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= 32'd0;
      cnt_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a framed program image (count header, big-endian words, checksum)
// from a byte stream into instruction memory while holding the processor.
module program_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        start,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  output logic        byteReady,
  output logic        memWrEn,
  output logic [31:0] memWrAddr,
  output logic [31:0] memWrData,
  output logic        cpuHold,
  output logic        done,
  output logic        error,
  output logic [15:0] wordsLoaded,
  output logic [2:0]  state_dbg
);

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  logic [2:0]        state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [CSUM_W-1:0] sum_q, sum_d;
  logic [15:0]       words_q, words_d;
  logic              wr_en_q, wr_en_d;
  logic [31:0]       wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              xfer;
  logic              asm_clear, asm_load, asm_full;
  logic [31:0]       asm_word;
  logic [15:0]       hdr_count;
  logic [CSUM_W-1:0] chk_sum;

  // Valid/ready: a byte moves on a rising edge where byteValid && byteReady.
  // byteReady depends only on state, never on byteValid, so the producer may
  // hold byteValid high for as long as it likes without creating a loop.
  assign byteReady = (state_q == ST_HDR_HI) || (state_q == ST_HDR_LO) ||
                     (state_q == ST_DATA)   || (state_q == ST_CHK);
  assign xfer      = byteValid && byteReady;
  assign hdr_count = {count_q[15:8], byteIn};
  assign chk_sum   = sum_q + byteIn;

  word_assembler u_asm (
    .clk       (Clk),
    .rst_n     (Rst),
    .clear     (asm_clear),
    .load      (asm_load),
    .byte_in   (byteIn),
    .word_next (asm_word),
    .word_full (asm_full)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    sum_d     = sum_q;
    words_d   = words_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    error_d   = error_q;
    asm_clear = 1'b0;
    asm_load  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          done_d    = 1'b0;
          error_d   = 1'b0;
          words_d   = 16'd0;
          sum_d     = '0;
          count_d   = 16'd0;
          asm_clear = 1'b1;
          state_d   = ST_HDR_HI;
        end
      end
      ST_HDR_HI: begin
        if (xfer) begin
          count_d[15:8] = byteIn;
          state_d       = ST_HDR_LO;
        end
      end
      ST_HDR_LO: begin
        if (xfer) begin
          count_d[7:0] = byteIn;
          if ({1'b0, hdr_count} > MAX_W) begin
            error_d = 1'b1;
            state_d = ST_ERR;
          end else if (hdr_count == 16'd0) begin
            state_d = ST_CHK;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          asm_load = 1'b1;
          sum_d    = chk_sum;
          // Capture address/data on entry so they are stable through WRITE.
          if (asm_full) begin
            wr_en_d   = 1'b1;
            wr_addr_d = word_addr(BASE_ADDR, words_q);
            wr_data_d = asm_word;
            state_d   = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        words_d = words_q + 16'd1;
        state_d = (words_q + 16'd1 == count_q) ? ST_CHK : ST_DATA;
      end
      ST_CHK: begin
        if (xfer) begin
          if (chk_sum == '0) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            error_d = 1'b1;
            state_d = ST_ERR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q   <= ST_IDLE;
      count_q   <= 16'd0;
      sum_q     <= '0;
      words_q   <= 16'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 32'd0;
      wr_data_q <= 32'd0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
      words_q   <= words_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign memWrEn     = wr_en_q;
  assign memWrAddr   = wr_addr_q;
  assign memWrData   = wr_data_q;
  assign cpuHold     = !((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                         (state_q == ST_ERR));
  assign done        = done_q;
  assign error       = error_q;
  assign wordsLoaded = words_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (base 0 and base 0x100) share one
// byte stream; a stream-level model predicts writes and final status.
module tb_program_loader;

  localparam int          MAXW   = 256;
  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam logic [31:0] BASE_B = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n, start, byte_valid;
  logic [7:0]  byte_in;

  logic        byte_ready_a, mem_wr_en_a, cpu_hold_a, done_a, error_a;
  logic [31:0] mem_wr_addr_a, mem_wr_data_a;
  logic [15:0] words_a;
  logic [2:0]  state_a;
  logic        byte_ready_b, mem_wr_en_b, cpu_hold_b, done_b, error_b;
  logic [31:0] mem_wr_addr_b, mem_wr_data_b;
  logic [15:0] words_b;
  logic [2:0]  state_b;

  int total = 0;
  int bad   = 0;
  int wr_seen_a = 0;
  int wr_seen_b = 0;
  logic [63:0] exp_a[$];
  logic [63:0] exp_b[$];
  logic [63:0] head_a, head_b;

  always #5 clk = ~clk;

  program_loader #(.BASE_ADDR(BASE_A), .MAX_WORDS(MAXW)) dut_a (
    .Clk(clk), .Rst(rst_n), .start(start), .byteIn(byte_in),
    .byteValid(byte_valid), .byteReady(byte_ready_a), .memWrEn(mem_wr_en_a),
    .memWrAddr(mem_wr_addr_a), .memWrData(mem_wr_data_a),
    .cpuHold(cpu_hold_a), .done(done_a), .error(error_a),
    .wordsLoaded(words_a), .state_dbg(state_a)
  );

  program_loader #(.BASE_ADDR(BASE_B), .MAX_WORDS(MAXW)) dut_b (
    .Clk(clk), .Rst(rst_n), .start(start), .byteIn(byte_in),
    .byteValid(byte_valid), .byteReady(byte_ready_b), .memWrEn(mem_wr_en_b),
    .memWrAddr(mem_wr_addr_b), .memWrData(mem_wr_data_b),
    .cpuHold(cpu_hold_b), .done(done_b), .error(error_b),
    .wordsLoaded(words_b), .state_dbg(state_b)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe is matched against the expected queue.
  always @(negedge clk) begin
    if (mem_wr_en_a) begin
      wr_seen_a++;
      check("ready_low_in_write_a", {63'd0, byte_ready_a}, 64'd0);
      if (exp_a.size() > 0) begin
        head_a = exp_a.pop_front();
        check("write_a", {mem_wr_addr_a, mem_wr_data_a}, head_a);
      end
    end
    if (mem_wr_en_b) begin
      wr_seen_b++;
      if (exp_b.size() > 0) begin
        head_b = exp_b.pop_front();
        check("write_b", {mem_wr_addr_b, mem_wr_data_b}, head_b);
      end
    end
  end

  task automatic do_start();
    @(negedge clk);
    start      = 1'b1;
    byte_valid = 1'($urandom_range(0, 1));
    byte_in    = 8'($urandom);
    @(negedge clk);
    start      = 1'b0;
    byte_valid = 1'b0;
    check("hold_after_start", {63'd0, cpu_hold_a}, 64'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps,
                           input bit pulse_start);
    bit sent = 0;
    bit go;
    int guard = 0;
    while (!sent) begin
      @(negedge clk);
      start = pulse_start;
      pulse_start = 0;
      if (gaps && $urandom_range(0, 2) == 0) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
      end else begin
        byte_valid = 1'b1;
        byte_in    = b;
      end
      #1;
      go = byte_valid && byte_ready_a;
      @(posedge clk);
      if (go) sent = 1;
      guard++;
      if (guard > 50) begin
        check("byte_timeout", 64'(guard), 64'd50);
        sent = 1;
      end
    end
  endtask

  // Model: framing rules only -- header count, big-endian words at
  // base+4*i, checksum over data bytes plus the trailing byte must be 0.
  task automatic run_load(input logic [7:0] s[$], input bit gaps,
                          input int busy_idx, input string name);
    int cnt, consumed, e_words;
    bit e_done;
    logic [7:0]  sum, tot;
    logic [31:0] w;
    cnt = (int'(s[0]) << 8) | int'(s[1]);
    wr_seen_a = 0;
    wr_seen_b = 0;
    if (cnt > MAXW) begin
      consumed = 2;
      e_done   = 0;
      e_words  = 0;
    end else begin
      consumed = 2 + 4 * cnt + 1;
      sum = 8'd0;
      for (int i = 0; i < cnt; i++) begin
        w = {s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]};
        sum = sum + s[2+4*i] + s[3+4*i] + s[4+4*i] + s[5+4*i];
        exp_a.push_back({BASE_A + 32'(4 * i), w});
        exp_b.push_back({BASE_B + 32'(4 * i), w});
      end
      tot     = sum + s[consumed-1];
      e_done  = (tot == 8'd0);
      e_words = cnt;
    end
    do_start();
    for (int i = 0; i < consumed; i++)
      send_byte(s[i], gaps, i == busy_idx);
    @(negedge clk);
    start      = 1'b0;
    byte_valid = 1'b0;
    if (cnt > MAXW) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = 8'($urandom);
        #1;
        check({name, ":ready_after_err"}, {63'd0, byte_ready_a}, 64'd0);
      end
      @(negedge clk);
      byte_valid = 1'b0;
    end
    repeat (3) @(negedge clk);
    check({name, ":done"},    {63'd0, done_a},  {63'd0, e_done});
    check({name, ":error"},   {63'd0, error_a}, {63'd0, !e_done});
    check({name, ":words"},   {48'd0, words_a}, 64'(e_words));
    check({name, ":hold"},    {63'd0, cpu_hold_a}, 64'd0);
    check({name, ":ready"},   {63'd0, byte_ready_a}, 64'd0);
    check({name, ":done_b"},  {63'd0, done_b},  {63'd0, e_done});
    check({name, ":words_b"}, {48'd0, words_b}, 64'(e_words));
    check({name, ":nwr_a"},   64'(wr_seen_a), 64'(e_words));
    check({name, ":nwr_b"},   64'(wr_seen_b), 64'(e_words));
    check({name, ":q_left"},  64'(exp_a.size() + exp_b.size()), 64'd0);
    exp_a.delete();
    exp_b.delete();
  endtask

  task automatic build(input int cnt, input bit good, output logic [7:0] s[$]);
    logic [7:0] sum, b;
    s = {};
    s.push_back(8'(cnt >> 8));
    s.push_back(8'(cnt));
    sum = 8'd0;
    for (int i = 0; i < 4 * cnt; i++) begin
      b = 8'($urandom);
      s.push_back(b);
      sum = sum + b;
    end
    if (good) s.push_back(8'd0 - sum);
    else      s.push_back(8'd0 - sum + 8'(1 + $urandom_range(0, 254)));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, ":ready"}, {63'd0, byte_ready_a}, 64'd0);
    check({name, ":wr_en"}, {63'd0, mem_wr_en_a}, 64'd0);
    check({name, ":addr_data"}, {mem_wr_addr_a, mem_wr_data_a}, 64'd0);
    check({name, ":hold"},  {63'd0, cpu_hold_a}, 64'd0);
    check({name, ":flags"}, {62'd0, done_a, error_a}, 64'd0);
    check({name, ":words"}, {48'd0, words_a}, 64'd0);
    check({name, ":state"}, {61'd0, state_a}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s[$];
    logic [7:0] nominal[$];
    int cnt;
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    nominal = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                8'h01, 8'h09, 8'h40, 8'h20, 8'h69};
    run_load(nominal, 0, -1, "nominal");

    s = nominal;
    s[10] = 8'h68;
    run_load(s, 0, -1, "bad_chk");

    s = '{8'h01, 8'h01};
    run_load(s, 0, -1, "oversize");

    s = '{8'h00, 8'h00, 8'h00};
    run_load(s, 0, -1, "zero");

    run_load(nominal, 1, -1, "backpressure");

    // Reset after the second data byte of word 1.
    do_start();
    for (int i = 0; i < 4; i++) send_byte(nominal[i], 0, 0);
    @(negedge clk);
    byte_valid = 1'b0;
    rst_n      = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_load(nominal, 0, -1, "after_reset");

    run_load(nominal, 0, 4, "busy_start");
    run_load(nominal, 1, 7, "busy_start_gaps");

    for (int t = 0; t < 10; t++) begin
      if ($urandom_range(0, 5) == 0) begin
        cnt = $urandom_range(MAXW + 1, 65535);
        s = {};
        s.push_back(8'(cnt >> 8));
        s.push_back(8'(cnt));
      end else begin
        build($urandom_range(0, 6), 1'($urandom_range(0, 1)), s);
      end
      run_load(s, 1'($urandom_range(0, 1)), $urandom_range(2, 12), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Writes a program image into instruction memory from a host-side byte stream. It is the write-side counterpart to the processor's instruction fetch, which only reads. Each image is a 2-byte word-count header, 4 bytes per word (big-endian), then one checksum byte. While loading, the block holds the processor so it cannot step, and it reports done or error status to the display/debug logic.

Parameters:
BASE_ADDR, 32'h00000000, byte address of the first word written
MAX_WORDS, 256, largest word count accepted in the header

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  reset; synchronous, active-low
start  in  1  single-cycle pulse that begins a load; ignored unless state is IDLE, DONE or ERR
byteIn  in  8  incoming stream byte
byteValid  in  1  byteIn is valid
byteReady  out  1  loader accepts byteIn this cycle
memWrEn  out  1  instruction-memory write strobe, one cycle per word
memWrAddr  out  32  byte address of the write
memWrData  out  32  assembled instruction word
cpuHold  out  1  high while loading; gates the processor step enable
done  out  1  sticky: last load succeeded
error  out  1  sticky: last load failed
wordsLoaded  out  16  number of words written in the current/last load

Behaviour:
- Reset (Rst=0 at a rising edge): state IDLE; every output is 0.
  - Reset mid-load abandons the load. memWrEn is 0 from that edge on.
  - Words already written stay in memory.
- Handshake: a byte transfers on an edge where byteValid and byteReady are both 1.
  - byteReady=1 only in HDR_HI, HDR_LO, DATA and CHK.
  - byteReady=0 in IDLE, WRITE, DONE and ERR.
  - byteValid without byteReady transfers nothing.
- cpuHold=1 in every state except IDLE, DONE and ERR.
- State transitions:
  - IDLE/DONE/ERR, on start: clear done, error, wordsLoaded, byte index, running sum and address offset -> HDR_HI.
  - HDR_HI, on transfer: count[15:8]=byte -> HDR_LO.
  - HDR_LO, on transfer: count[7:0]=byte.
    - count > MAX_WORDS -> ERR. No writes occur.
    - count == 0 -> CHK.
    - otherwise -> DATA.
  - DATA, on transfer:
    - Shift the byte into the word: first byte goes to [31:24], last to [7:0].
    - Add the byte to the 8-bit running sum, mod 256.
    - On the 4th byte -> WRITE.
  - WRITE (exactly 1 cycle):
    - memWrEn=1, memWrAddr=BASE_ADDR+4*wordsLoaded, memWrData=assembled word.
    - wordsLoaded increments at the end of the cycle.
    - If the new wordsLoaded == count -> CHK, else -> DATA.
  - CHK, on transfer:
    - (sum+byte) mod 256 == 0 -> DONE, done=1.
    - otherwise -> ERR, error=1.
  - DONE and ERR hold until start or reset; done/error stay asserted.
- Header bytes do not enter the checksum.
- Throughput is at most 4 bytes per 5 cycles.
- Latency: memWrEn rises the cycle after the 4th byte of a word transfers.
- memWrAddr and memWrData are registered. Outside WRITE they hold their last values, but only memWrEn qualifies them.
- Address arithmetic is 32-bit and wraps silently. With MAX_WORDS ≤ 16384 it never wraps from BASE_ADDR 0.
- start while busy (any state other than IDLE, DONE, ERR) is ignored.
- start in the same cycle as a byteValid in IDLE: the byte is not accepted; HDR_HI begins next cycle.

Decomposition:
- Shared package loader_pkg:
  - state enumeration: IDLE, HDR_HI, HDR_LO, DATA, WRITE, CHK, DONE, ERR
  - HDR_BYTES=2, BYTES_PER_WORD=4
  - 8-bit checksum width constant
- One sub-module, word_assembler: a 4-byte big-endian shift register with a 2-bit byte counter and a word_full flag. It has load, clear and Rst inputs.
- The FSM, address counter and checksum stay in program_loader.

Test Plan:
- Nominal load:
  - Stimulus: start, then bytes 00 02 | 20 08 00 05 | 01 09 40 20 | 69.
  - Writes: 0x20080005 @0x0 and 0x01094020 @0x4, one memWrEn pulse each.
  - End state: done=1, error=0, wordsLoaded=2, cpuHold falls after the checksum byte.
- Bad checksum: same stream with checksum 0x68 -> both writes still occur; error=1, done=0.
- Oversize header: 01 01 (257) with MAX_WORDS=256 -> ERR after 2nd byte, no memWrEn, error=1, byteReady=0 afterwards.
- Zero count and backpressure:
  - Zero count: 00 00 00 -> no writes, done=1, wordsLoaded=0.
  - Backpressure: byteValid toggled randomly with the 2-word stream -> identical writes. byteReady=0 in each WRITE cycle, and no byte is lost or duplicated.
- Reset mid-load: Rst=0 after the 2nd data byte of word 1 -> next edge all outputs 0, state IDLE. A fresh start followed by the nominal stream loads correctly.
- Start while busy: start pulsed during DATA -> ignored, load completes normally. BASE_ADDR=0x100 variant -> writes at 0x100 and 0x104.
